// File: rtl/simple_fifo_wr_arbiter_if.sv
// simple_fifo_wr_arbiter_if
//   Bundles the requester-side valid/ack/data signals and the FIFO write-port
//   pins shared by one simple_fifo_wr_arbiter instance.
//   Ports (signals):
//     req       [NREQ]        requester i holds a valid word
//     din       [NREQ*WIDTH]  requester i's word on [i*WIDTH +: WIDTH]
//     ack       [NREQ]        one-hot/zero, requester i's word written this cycle
//     fifo_we                 FIFO write enable
//     fifo_din  [WIDTH]       FIFO write data
//     fifo_full               FIFO full flag
//   Modports: master = arbiter, slave = requesters + FIFO environment.
interface simple_fifo_wr_arbiter_if #(
    parameter int WIDTH = 128,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] din;
    logic [NREQ-1:0]       ack;
    logic                  fifo_we;
    logic [WIDTH-1:0]      fifo_din;
    logic                  fifo_full;

    modport master (
        input  req, din, fifo_full,
        output ack, fifo_we, fifo_din
    );

    modport slave (
        output req, din, fifo_full,
        input  ack, fifo_we, fifo_din
    );
endinterface

// File: rtl/simple_fifo_wr_arbiter.sv
// simple_fifo_wr_arbiter
//   Round-robin arbiter sharing one FIFO write port among NREQ requesters.
//   A granted requester owns the port for up to BURST words, then the port
//   is released and re-arbitrated starting after the released owner.
//   Ports:
//     clk    in   single clock, rising edge
//     reset  in   synchronous, active-high
//     bus    if   master modport: req/din/ack and fifo_we/fifo_din/fifo_full
//     busy   out  registered, high while a requester owns the port
//     owner  out  registered, index of current or last granted requester
module simple_fifo_wr_arbiter #(
    parameter int WIDTH = 128,
    parameter int NREQ  = 4,
    parameter int BURST = 4,
    localparam int OW   = $clog2(NREQ),
    localparam int CW   = $clog2(BURST) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    simple_fifo_wr_arbiter_if.master  bus,
    output logic                      busy,
    output logic [OW-1:0]             owner
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] ptr_q,   ptr_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic [OW-1:0] sel;
    logic          sel_vld;
    logic          own_req;
    logic          we;

    // (a + k) mod NREQ for k in 0..NREQ-1; avoids relying on power-of-two wrap.
    function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= NREQ) s = s - NREQ;
        return OW'(s);
    endfunction

    // First requester found scanning upward from ptr_q, wrapping.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!sel_vld && bus.req[wrap_add(ptr_q, k)]) begin
                sel_vld = 1'b1;
                sel     = wrap_add(ptr_q, k);
            end
        end
    end

    // Reset gates the write so a mid-burst reset cycle never writes.
    always_comb begin
        own_req      = bus.req[owner_q];
        we           = (state_q == OWN) && own_req && !bus.fifo_full && !reset;
        bus.fifo_we  = we;
        bus.ack      = '0;
        if (we) bus.ack[owner_q] = 1'b1;
        bus.fifo_din = '0;
        if (state_q == OWN) bus.fifo_din = bus.din[int'(owner_q)*WIDTH +: WIDTH];
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    state_d = OWN;
                    owner_d = sel;
                    cnt_d   = '0;
                end
            end
            OWN: begin
                if (!own_req) begin
                    state_d = IDLE;
                    ptr_d   = wrap_add(owner_q, 1);
                end else if (we) begin
                    if (cnt_q == CW'(BURST - 1)) begin
                        state_d = IDLE;
                        ptr_d   = wrap_add(owner_q, 1);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                // fifo_full with req held: everything holds (stall).
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy  = (state_q == OWN);
    assign owner = owner_q;

endmodule

// File: tb/tb_simple_fifo_wr_arbiter.sv
module tb_simple_fifo_wr_arbiter;
    localparam int W = 16;
    localparam int N = 4;
    localparam int B = 4;
    localparam int NV = 11;

    logic       clk;
    logic       reset;
    logic       busy;
    logic [1:0] owner;

    simple_fifo_wr_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

    simple_fifo_wr_arbiter #(.WIDTH(W), .NREQ(N), .BURST(B)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         full;
        logic [N-1:0] ack;
        logic         we;
        logic         busy;
        logic [1:0]   owner;
        logic         chk_din;
        logic [W-1:0] din;
    } vec_t;

    vec_t vecs[NV];

    // Requester model and per-cycle logs for the sequence scenarios.
    int           rem[N];
    int           seq[N];
    int           cyc;
    logic         we_log[64];
    logic [N-1:0] ack_log[64];
    logic         busy_log[64];
    logic [1:0]   own_log[64];
    logic [W-1:0] din_log[64];
    logic [W-1:0] got[$];

    function automatic logic [W-1:0] word(input int i, input int s);
        return W'(i * 4096 + s);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        for (int i = 0; i < N; i++) begin
            bus.req[i]          = (rem[i] > 0);
            bus.din[i*W +: W]   = word(i, seq[i]);
        end
        @(negedge clk);
        if (cyc < 64) begin
            we_log[cyc]   = bus.fifo_we;
            ack_log[cyc]  = bus.ack;
            busy_log[cyc] = busy;
            own_log[cyc]  = owner;
            din_log[cyc]  = bus.fifo_din;
        end
        check($sformatf("no_overflow[%0d]", cyc), 32'(bus.fifo_we & bus.fifo_full), 32'd0);
        if (bus.fifo_we) got.push_back(bus.fifo_din);
        for (int i = 0; i < N; i++) begin
            if (bus.ack[i]) begin
                seq[i]++;
                rem[i]--;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.fifo_full = 1'b0;
        bus.req       = '0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        got.delete();
    endtask

    task automatic check_words(input string nm, input int n_exp, input int who, input int first);
        check({nm, "_count"}, 32'(got.size()), 32'(n_exp));
        for (int k = 0; k < n_exp && k < got.size(); k++)
            check($sformatf("%s_word[%0d]", nm, k), 32'(got[k]), 32'(word(who, first + k)));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;

        vecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, word(0, 0) & 16'h0};
        vecs[1]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 16'h0};
        vecs[2]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, word(2, 0)};
        vecs[3]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b1, word(2, 0)};
        vecs[4]  = '{1'b0, 4'b0110, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, word(2, 0)};
        vecs[5]  = '{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b1, word(2, 0)};
        vecs[6]  = '{1'b0, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b1, 16'h0};
        vecs[7]  = '{1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, word(0, 0)};
        vecs[8]  = '{1'b1, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0};
        vecs[9]  = '{1'b0, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 16'h0};
        vecs[10] = '{1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, word(0, 0)};

        // Table-driven cycles, starting from a settled reset.
        reset         = 1'b1;
        bus.req       = '0;
        bus.fifo_full = 1'b0;
        for (int i = 0; i < N; i++) bus.din[i*W +: W] = word(i, 0);
        repeat (2) @(posedge clk);
        #1;
        for (int v = 0; v < NV; v++) begin
            reset         = vecs[v].rst;
            bus.req       = vecs[v].req;
            bus.fifo_full = vecs[v].full;
            @(negedge clk);
            check($sformatf("vec%0d_ack", v),   32'(bus.ack),     32'(vecs[v].ack));
            check($sformatf("vec%0d_we", v),    32'(bus.fifo_we), 32'(vecs[v].we));
            check($sformatf("vec%0d_busy", v),  32'(busy),        32'(vecs[v].busy));
            check($sformatf("vec%0d_owner", v), 32'(owner),       32'(vecs[v].owner));
            if (vecs[v].chk_din)
                check($sformatf("vec%0d_din", v), 32'(bus.fifo_din), 32'(vecs[v].din));
            @(posedge clk);
            #1;
        end

        // Single requester, 8 words: writes 1-4, gap at 5, writes 6-9.
        do_reset();
        rem[0] = 8;
        for (int c = 0; c < 12; c++) tick();
        for (int c = 0; c < 12; c++)
            check($sformatf("s1_we[%0d]", c), 32'(we_log[c]),
                  32'((c >= 1 && c <= 4) || (c >= 6 && c <= 9)));
        check_words("s1", 8, 0, 0);

        // All four requesting: grants 0,1,2,3,0, four words each.
        do_reset();
        for (int i = 0; i < N; i++) rem[i] = 1000;
        for (int c = 0; c < 25; c++) tick();
        for (int c = 0; c < 25; c++) begin
            check($sformatf("s2_we[%0d]", c),   32'(we_log[c]),   32'(c % 5 != 0));
            check($sformatf("s2_busy[%0d]", c), 32'(busy_log[c]), 32'(c % 5 != 0));
            check($sformatf("s2_ack[%0d]", c),  32'(ack_log[c]),
                  (c % 5 != 0) ? (32'd1 << ((c / 5) % 4)) : 32'd0);
            if (c % 5 != 0)
                check($sformatf("s2_owner[%0d]", c), 32'(own_log[c]), 32'((c / 5) % 4));
        end
        check("s2_count", 32'(got.size()), 32'd20);
        for (int k = 0; k < 20 && k < got.size(); k++)
            check($sformatf("s2_word[%0d]", k), 32'(got[k]),
                  32'(word((k / 4) % 4, ((k / 4) / 4) * 4 + k % 4)));

        // Full stall for 3 cycles at cnt=2.
        do_reset();
        rem[0] = 6;
        for (int c = 0; c < 11; c++) begin
            bus.fifo_full = (c >= 3 && c <= 5);
            tick();
        end
        bus.fifo_full = 1'b0;
        for (int c = 0; c < 11; c++)
            check($sformatf("s3_we[%0d]", c), 32'(we_log[c]),
                  32'(c == 1 || c == 2 || c == 6 || c == 7 || c == 9 || c == 10));
        for (int c = 3; c <= 5; c++)
            check($sformatf("s3_ack[%0d]", c), 32'(ack_log[c]), 32'd0);
        check("s3_busy[8]", 32'(busy_log[8]), 32'd0);
        check_words("s3", 6, 0, 0);

        // Early drop of requester 1 while 2 requests.
        do_reset();
        rem[1] = 2;
        rem[2] = 4;
        for (int c = 0; c < 7; c++) tick();
        check("s4_ack[1]",   32'(ack_log[1]),  32'b0010);
        check("s4_ack[2]",   32'(ack_log[2]),  32'b0010);
        check("s4_we[3]",    32'(we_log[3]),   32'd0);
        check("s4_busy[3]",  32'(busy_log[3]), 32'd1);
        check("s4_busy[4]",  32'(busy_log[4]), 32'd0);
        check("s4_owner[5]", 32'(own_log[5]),  32'd2);
        check("s4_ack[5]",   32'(ack_log[5]),  32'b0100);
        check("s4_count",    32'(got.size()),  32'd4);
        if (got.size() >= 3) check("s4_word2", 32'(got[2]), 32'(word(2, 0)));

        // Priority wrap: ptr=2 with req=1010 grants 3, then 1.
        do_reset();
        rem[1] = 1;
        for (int c = 0; c < 3; c++) tick();
        rem[1] = 2;
        rem[3] = 6;
        for (int c = 3; c < 11; c++) tick();
        check("s5_busy[3]",  32'(busy_log[3]), 32'd0);
        check("s5_owner[4]", 32'(own_log[4]),  32'd3);
        check("s5_ack[4]",   32'(ack_log[4]),  32'b1000);
        check("s5_ack[7]",   32'(ack_log[7]),  32'b1000);
        check("s5_busy[8]",  32'(busy_log[8]), 32'd0);
        check("s5_owner[9]", 32'(own_log[9]),  32'd1);
        check("s5_ack[9]",   32'(ack_log[9]),  32'b0010);

        // Reset mid-burst at cnt=1 with req[3] held.
        do_reset();
        rem[3] = 10;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("s6_ack[1]",   32'(ack_log[1]),  32'b1000);
        check("s6_we[2]",    32'(we_log[2]),   32'd0);
        check("s6_ack[2]",   32'(ack_log[2]),  32'd0);
        check("s6_busy[3]",  32'(busy_log[3]), 32'd0);
        check("s6_owner[3]", 32'(own_log[3]),  32'd0);
        check("s6_we[3]",    32'(we_log[3]),   32'd0);
        check("s6_din[3]",   32'(din_log[3]),  32'd0);
        check("s6_busy[4]",  32'(busy_log[4]), 32'd1);
        check("s6_owner[4]", 32'(own_log[4]),  32'd3);
        check("s6_ack[4]",   32'(ack_log[4]),  32'b1000);
        check_words("s6", 2, 3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/simple_fifo_wr_arbiter.md
# simple_fifo_wr_arbiter

Round-robin write arbiter that shares one `simple_fifo` write port among `NREQ` requesters. Each requester presents a word with a valid/ack handshake. The arbiter grants one requester at a time for a burst of up to `BURST` words, then drives the FIFO `we`/`din` pins and stalls on `full`. It sits directly in front of the shared FIFO instance.

## Interface
- `WIDTH`, 128: data word width; must match the FIFO's `WIDTH`.
- `NREQ`, 4: number of requesters, 2..16.
- `BURST`, 4: maximum words written per grant, at least 1.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req` in NREQ: bit i high means requester i holds a valid word on its slice of `din`.
- `din` in NREQ*WIDTH: requester i's word on bits [i*WIDTH +: WIDTH].
- `ack` out NREQ: one-hot or zero; bit i high means requester i's word is written this cycle.
- `fifo_we` out 1: to FIFO `we`.
- `fifo_din` out WIDTH: to FIFO `din`.
- `fifo_full` in 1: from FIFO `full`.
- `busy` out 1: high in OWN state.
- `owner` out clog2(NREQ): index of the current or last granted requester.

## Operation
- The FSM has two states.
  - IDLE: no requester owns the port.
  - OWN: requester `owner` owns the port.
- Registered state:
  - `state`
  - `owner`
  - `ptr`: round-robin start index.
  - `cnt`: words written in the current grant, width clog2(BURST)+1.
- IDLE behaviour:
  - If `req` is nonzero, select the first set bit scanning upward from `ptr`, wrapping modulo NREQ.
  - Next cycle: state=OWN, `owner`=selected index, `cnt`=0.
  - If `req` is zero, stay in IDLE.
- OWN behaviour (combinational outputs):
  - `fifo_we` = `req[owner]` & ~`fifo_full`.
  - `ack[owner]` = `fifo_we`; all other `ack` bits are 0.
  - `fifo_din` = `din` slice of `owner`.
- OWN transitions, in priority order:
  - `req[owner]`=0: go to IDLE, `ptr`=`owner`+1 mod NREQ. No write that cycle.
  - Write with `cnt`==BURST-1: go to IDLE, `ptr`=`owner`+1 mod NREQ.
  - Write otherwise: `cnt`++, stay in OWN.
  - `fifo_full` with `req[owner]`=1: stall. `cnt` and `owner` hold, `ack`=0, `fifo_we`=0.
- In IDLE, `fifo_we`=0, `ack`=0 and `fifo_din`=0.
- Requester rules:
  - A requester must hold `req` and its word stable until acked.
  - After an ack it may present the next word in the next cycle or drop `req`.
  - Dropping `req` before an ack is permitted; the word is not written.
- Fairness: the owner just released has the lowest priority at the next arbitration. Any continuously requesting requester is granted within NREQ arbitrations.
- `fifo_we` is never asserted while `fifo_full`=1, so the FIFO cannot overflow.

## Timing
- Reset values:
  - `state`=IDLE, `ptr`=0, `owner`=0, `cnt`=0.
  - `ack`=0, `fifo_we`=0, `fifo_din`=0, `busy`=0.
- Reset has priority over all other inputs. Reset mid-burst drops ownership with no write in the reset cycle; the FIFO is reset separately.
- Latency: `req` rising at cycle t in IDLE gives the first write at t+1, provided the FIFO is not full.
- Each release costs one idle arbitration cycle. With continuous requests, throughput is BURST words per BURST+1 cycles.
- `fifo_full` acts on the write in the same cycle, with no pipeline between the arbiter and the FIFO.
- `busy` and `owner` are registered outputs. `ack`, `fifo_we` and `fifo_din` are combinational from registered state plus `req`, `din` and `fifo_full`.

## Test plan
- **Single requester, long burst:** NREQ=4, BURST=4; `req[0]` held for 8 words.
  - Writes occur at cycles 1–4, then an IDLE gap at cycle 5, then writes at cycles 6–9.
  - The FIFO receives words 0..7 in order.
- **All four requesting continuously:** grants go in the order 0,1,2,3,0.
  - Each grant writes exactly 4 words.
  - `owner` increments after every 5 cycles.
- **Full stall:** `fifo_full` forced high for 3 cycles mid-burst, at `cnt`=2.
  - `ack` and `fifo_we` are 0 for those 3 cycles.
  - After the stall, exactly 2 more words are written before release.
  - No word is lost or duplicated.
- **Early drop:** `req[1]` drops after 2 acks while `req[2]` is high.
  - Next cycle is IDLE, then owner=2.
  - `ptr`=2 at the time of that arbitration.
- **Priority wrap:** `ptr`=2 with `req`=4'b1010.
  - Requester 3 is granted.
  - On its release `ptr`=0, and requester 1 is granted next.
- **Reset mid-burst:** `reset` asserted at `cnt`=1.
  - Next cycle all outputs are at reset values, `busy`=0 and `ptr`=0.
  - A held `req[3]` is re-granted one cycle after `reset` deasserts.
